// File: rtl/tcp_vlg_tx_opt.sv
// TCP option serialiser: latches option fields on start, reports opt_len/offset one cycle later, then streams bytes under val/rdy.
// Define TCP_VLG_SACK_EN to enable the SACK-permitted and SACK options (otherwise their inputs are ignored).
module tcp_vlg_tx_opt #(
  parameter int MAX_OPT_BYTES = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mss_pres,
  input  logic [15:0]      mss,
  input  logic             wnd_pres,
  input  logic [7:0]       wnd,
  input  logic             sack_perm_pres,
  input  logic             ts_pres,
  input  logic [31:0]      ts_snd,
  input  logic [31:0]      ts_rec,
  input  logic             sack_pres,
  input  logic [3:0][63:0] sack_blk,
  input  logic [3:0]       sack_blk_pres,
  input  logic             rdy,
  output logic [7:0]       dat,
  output logic             val,
  output logic             len_val,
  output logic [5:0]       opt_len,
  output logic [3:0]       offset,
  output logic             busy,
  output logic             done
);

`ifdef TCP_VLG_SACK_EN
  typedef enum logic [2:0] {IDLE, CALC, MSS, WND, SPERM, TS, SACK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CALC, MSS, WND, TS, DONE} state_t;
`endif

  state_t      state_q, state_d;
  state_t      nxt, nxt_calc, nxt_mss, nxt_wnd, nxt_sperm, nxt_ts;
  logic [5:0]  cnt_q, cnt_d, last_idx;
  logic        emit;
  logic        mss_p_q, mss_p_d, wnd_p_q, wnd_p_d, ts_p_q, ts_p_d;
  logic [15:0] mss_q, mss_d;
  logic [3:0]  scl_q, scl_d;
  logic [63:0] ts_q, ts_d;
  logic        len_val_q, len_val_d;
  logic [5:0]  opt_len_q, opt_len_d;
  logic [3:0]  offset_q, offset_d;
  logic        start_acc;
  logic [6:0]  base_len, sperm_len;
  logic [5:0]  calc_len;

  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign start_acc = start && !busy;
  assign len_val   = len_val_q;
  assign opt_len   = opt_len_q;
  assign offset    = offset_q;

  assign base_len = (mss_pres ? 7'd4 : 7'd0) + (wnd_pres ? 7'd4 : 7'd0)
                  + (ts_pres ? 7'd12 : 7'd0) + sperm_len;

  function automatic logic [7:0] byte_sel(input logic [63:0] w, input logic [2:0] i);
    logic [63:0] t;
    t = w << {i, 3'b000};
    return t[63:56];
  endfunction

`ifdef TCP_VLG_SACK_EN
  logic             sperm_p_q, sperm_p_d, sack_p_q, sack_p_d;
  logic [2:0]       n_q, n_d, n_calc, pop, k;
  logic [3:0][63:0] blk_q, blk_d, blk_sel;
  logic [6:0]       sack_len;
  logic [1:0]       blk_idx;

  assign sperm_len = sack_perm_pres ? 7'd4 : 7'd0;
  assign blk_idx   = 2'((cnt_q - 6'd4) >> 3);

  // Largest block count that fits the byte budget; present blocks are packed low-index first.
  always_comb begin
    pop = 3'd0;
    for (int i = 0; i < 4; i++) pop = pop + {2'b00, sack_blk_pres[i]};
    n_calc = 3'd0;
    for (int j = 1; j <= 4; j++)
      if (j <= int'(pop) && int'(base_len) + 4 + 8 * j <= MAX_OPT_BYTES) n_calc = 3'(j);
    sack_len = (sack_pres && n_calc != 3'd0) ? 7'd4 + {1'b0, n_calc, 3'b000} : 7'd0;
    k       = 3'd0;
    blk_sel = '0;
    for (int i = 0; i < 4; i++)
      if (sack_blk_pres[i] && k < n_calc) begin
        blk_sel[k[1:0]] = sack_blk[i];
        k = k + 3'd1;
      end
  end

  assign calc_len = 6'(base_len + sack_len);

  always_comb begin
    sperm_p_d = sperm_p_q;
    sack_p_d  = sack_p_q;
    n_d       = n_q;
    blk_d     = blk_q;
    if (start_acc) begin
      sperm_p_d = sack_perm_pres;
      sack_p_d  = sack_pres && (n_calc != 3'd0);
      n_d       = n_calc;
      blk_d     = blk_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sperm_p_q <= 1'b0;
      sack_p_q  <= 1'b0;
      n_q       <= 3'd0;
      blk_q     <= '0;
    end else begin
      sperm_p_q <= sperm_p_d;
      sack_p_q  <= sack_p_d;
      n_q       <= n_d;
      blk_q     <= blk_d;
    end
  end
`else
  logic unused_sack;
  assign unused_sack = ^{sack_perm_pres, sack_pres, sack_blk, sack_blk_pres};
  assign sperm_len   = 7'd0;
  assign calc_len    = 6'(base_len);
`endif

  always_comb begin
    mss_p_d   = mss_p_q;
    wnd_p_d   = wnd_p_q;
    ts_p_d    = ts_p_q;
    mss_d     = mss_q;
    scl_d     = scl_q;
    ts_d      = ts_q;
    opt_len_d = opt_len_q;
    offset_d  = offset_q;
    len_val_d = start_acc;
    if (start_acc) begin
      mss_p_d   = mss_pres;
      wnd_p_d   = wnd_pres;
      ts_p_d    = ts_pres;
      mss_d     = mss;
      scl_d     = (wnd > 8'd14) ? 4'd14 : wnd[3:0];
      ts_d      = {ts_snd, ts_rec};
      opt_len_d = calc_len;
      offset_d  = 4'(6'd5 + (calc_len >> 2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mss_p_q   <= 1'b0;
      wnd_p_q   <= 1'b0;
      ts_p_q    <= 1'b0;
      mss_q     <= 16'd0;
      scl_q     <= 4'd0;
      ts_q      <= 64'd0;
      len_val_q <= 1'b0;
      opt_len_q <= 6'd0;
      offset_q  <= 4'd5;
      cnt_q     <= 6'd0;
    end else begin
      mss_p_q   <= mss_p_d;
      wnd_p_q   <= wnd_p_d;
      ts_p_q    <= ts_p_d;
      mss_q     <= mss_d;
      scl_q     <= scl_d;
      ts_q      <= ts_d;
      len_val_q <= len_val_d;
      opt_len_q <= opt_len_d;
      offset_q  <= offset_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Successor chain: each state skips forward over absent options.
  always_comb begin
`ifdef TCP_VLG_SACK_EN
    nxt_ts    = sack_p_q ? SACK : DONE;
    nxt_sperm = ts_p_q ? TS : nxt_ts;
    nxt_wnd   = sperm_p_q ? SPERM : nxt_sperm;
`else
    nxt_ts    = DONE;
    nxt_sperm = ts_p_q ? TS : nxt_ts;
    nxt_wnd   = nxt_sperm;
`endif
    nxt_mss  = wnd_p_q ? WND : nxt_wnd;
    nxt_calc = mss_p_q ? MSS : nxt_mss;
    state_d  = state_q;
    cnt_d    = cnt_q;
    nxt      = DONE;
    emit     = 1'b0;
    last_idx = 6'd3;
    case (state_q)
      IDLE, DONE: begin
        cnt_d   = 6'd0;
        state_d = start_acc ? ((calc_len == 6'd0) ? DONE : CALC) : IDLE;
      end
      CALC: state_d = nxt_calc;
      MSS:  begin emit = 1'b1; nxt = nxt_mss; end
      WND:  begin emit = 1'b1; nxt = nxt_wnd; end
`ifdef TCP_VLG_SACK_EN
      SPERM: begin emit = 1'b1; nxt = nxt_sperm; end
      SACK:  begin emit = 1'b1; nxt = DONE; last_idx = 6'd3 + {n_q, 3'b000}; end
`endif
      TS:   begin emit = 1'b1; nxt = nxt_ts; last_idx = 6'd11; end
      default: state_d = IDLE;
    endcase
    if (emit && rdy) begin
      if (cnt_q == last_idx) begin
        state_d = nxt;
        cnt_d   = 6'd0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_comb begin
    val = 1'b0;
    dat = 8'h00;
    case (state_q)
      MSS: begin
        val = 1'b1;
        case (cnt_q[1:0])
          2'd0:    dat = 8'h02;
          2'd1:    dat = 8'h04;
          2'd2:    dat = mss_q[15:8];
          default: dat = mss_q[7:0];
        endcase
      end
      WND: begin
        val = 1'b1;
        case (cnt_q[1:0])
          2'd0:    dat = 8'h01;
          2'd3:    dat = {4'h0, scl_q};
          default: dat = 8'h03;
        endcase
      end
`ifdef TCP_VLG_SACK_EN
      SPERM: begin
        val = 1'b1;
        case (cnt_q[1:0])
          2'd2:    dat = 8'h04;
          2'd3:    dat = 8'h02;
          default: dat = 8'h01;
        endcase
      end
      SACK: begin
        val = 1'b1;
        if (cnt_q < 6'd4) begin
          case (cnt_q[1:0])
            2'd2:    dat = 8'h05;
            2'd3:    dat = 8'({n_q, 3'b000}) + 8'd2;
            default: dat = 8'h01;
          endcase
        end else begin
          dat = byte_sel(blk_q[blk_idx], cnt_q[2:0] - 3'd4);
        end
      end
`endif
      TS: begin
        val = 1'b1;
        if (cnt_q < 6'd4) begin
          case (cnt_q[1:0])
            2'd2:    dat = 8'h08;
            2'd3:    dat = 8'h0A;
            default: dat = 8'h01;
          endcase
        end else begin
          dat = byte_sel(ts_q, cnt_q[2:0] - 3'd4);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tcp_vlg_tx_opt.sv
// Directed bench for tcp_vlg_tx_opt; SACK expectations follow TCP_VLG_SACK_EN.
module tb_tcp_vlg_tx_opt;
  logic             clk = 1'b0;
  logic             rst, start, mss_pres, wnd_pres, sack_perm_pres, ts_pres, sack_pres, rdy;
  logic [15:0]      mss;
  logic [7:0]       wnd;
  logic [31:0]      ts_snd, ts_rec;
  logic [3:0][63:0] sack_blk;
  logic [3:0]       sack_blk_pres;
  logic [7:0]       dat;
  logic             val, len_val, busy, done;
  logic [5:0]       opt_len;
  logic [3:0]       offset;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  tcp_vlg_tx_opt #(.MAX_OPT_BYTES(40)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mss_pres(mss_pres), .mss(mss), .wnd_pres(wnd_pres), .wnd(wnd),
    .sack_perm_pres(sack_perm_pres), .ts_pres(ts_pres), .ts_snd(ts_snd), .ts_rec(ts_rec),
    .sack_pres(sack_pres), .sack_blk(sack_blk), .sack_blk_pres(sack_blk_pres),
    .rdy(rdy), .dat(dat), .val(val), .len_val(len_val), .opt_len(opt_len),
    .offset(offset), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push32(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic clear_inputs();
    mss_pres = 0; mss = 0; wnd_pres = 0; wnd = 0; sack_perm_pres = 0;
    ts_pres = 0; ts_snd = 0; ts_rec = 0; sack_pres = 0; sack_blk = '0; sack_blk_pres = 0;
    exp_q.delete();
  endtask

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic run_job(input string name, input int exp_len, input int exp_off,
                         input bit toggle, input bit second);
    int got, cyc;
    bit hold_v;
    logic [7:0] hold_d;
    got = 0; cyc = 0; hold_v = 0; hold_d = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    chk({name, "/len_val"}, len_val, 1);
    chk({name, "/opt_len"}, opt_len, exp_len);
    chk({name, "/offset"}, offset, exp_off);
    if (exp_len == 0) begin
      chk({name, "/done"}, done, 1);
      chk({name, "/busy"}, busy, 0);
      chk({name, "/val"}, val, 0);
      @(negedge clk);
      chk({name, "/len_val_off"}, len_val, 0);
      chk({name, "/done_off"}, done, 0);
      chk({name, "/val_off"}, val, 0);
      return;
    end
    chk({name, "/busy"}, busy, 1);
    while (got < exp_len && cyc < 200) begin
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      start = (second && cyc == 2);
      if (hold_v) begin
        chk({name, "/hold"}, dat, hold_d);
        hold_v = 0;
      end
      chk({name, "/val_idle"}, val & ~busy, 0);
      chk({name, "/done_early"}, done, 0);
      if (val && rdy) begin
        chk({name, "/byte"}, dat, exp_q[got]);
        got++;
      end else if (val) begin
        hold_v = 1;
        hold_d = dat;
      end
      @(negedge clk);
      cyc++;
    end
    start = 0;
    rdy = 1;
    if (got < exp_len) chk({name, "/timeout_bytes"}, got, exp_len);
    chk({name, "/done"}, done, 1);
    chk({name, "/busy_end"}, busy, 0);
    chk({name, "/val_end"}, val, 0);
    @(negedge clk);
    chk({name, "/done_off"}, done, 0);
    chk({name, "/val_after"}, val, 0);
    chk({name, "/busy_after"}, busy, 0);
  endtask

  initial begin
    int got;
    clear_inputs();
    rst = 1; start = 0; rdy = 1;
    repeat (2) @(negedge clk);
    chk("rst/dat", dat, 0);
    chk("rst/val", val, 0);
    chk("rst/len_val", len_val, 0);
    chk("rst/opt_len", opt_len, 0);
    chk("rst/offset", offset, 5);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    rst = 0;
    @(negedge clk);

    mss_pres = 1; mss = 16'h05B4;
    push32(32'h020405B4);
    run_job("mss", 4, 6, 0, 0);

    clear_inputs();
    mss_pres = 1; mss = 16'h05B4; wnd_pres = 1; wnd = 8'd20; sack_perm_pres = 1;
    ts_pres = 1; ts_snd = 32'h11223344; ts_rec = 32'h0;
    push32(32'h020405B4); push32(32'h0103030E);
`ifdef TCP_VLG_SACK_EN
    push32(32'h01010402);
`endif
    push32(32'h0101080A); push32(32'h11223344); push32(32'h00000000);
`ifdef TCP_VLG_SACK_EN
    run_job("full", 24, 11, 0, 0);
`else
    run_job("full", 20, 10, 0, 0);
`endif

    clear_inputs();
    ts_pres = 1; ts_snd = 32'hAABBCCDD; ts_rec = 32'h01020304;
    sack_pres = 1; sack_blk_pres = 4'b1111;
    for (int i = 0; i < 4; i++) sack_blk[i] = {32'h10000000 + i, 32'h20000000 + i};
    push32(32'h0101080A); push32(32'hAABBCCDD); push32(32'h01020304);
`ifdef TCP_VLG_SACK_EN
    push32(32'h0101051A);
    push32(32'h10000000); push32(32'h20000000);
    push32(32'h10000001); push32(32'h20000001);
    push32(32'h10000002); push32(32'h20000002);
    run_job("sack_trunc", 40, 15, 0, 0);
`else
    run_job("sack_trunc", 12, 8, 0, 0);
`endif

    clear_inputs();
    mss_pres = 1; mss = 16'h0218; sack_pres = 1; sack_blk_pres = 4'b1010;
    for (int i = 0; i < 4; i++) sack_blk[i] = {32'h10000000 + i, 32'h20000000 + i};
    push32(32'h02040218);
`ifdef TCP_VLG_SACK_EN
    push32(32'h01010512);
    push32(32'h10000001); push32(32'h20000001);
    push32(32'h10000003); push32(32'h20000003);
    run_job("sack_sparse", 24, 11, 0, 0);
`else
    run_job("sack_sparse", 4, 6, 0, 0);
`endif

    clear_inputs();
    run_job("empty", 0, 5, 0, 0);

    clear_inputs();
    mss_pres = 1; mss = 16'hABCD;
    push32(32'h0204ABCD);
    run_job("toggle", 4, 6, 1, 1);

    clear_inputs();
    mss_pres = 1; mss = 16'h05B4; wnd_pres = 1; wnd = 8'd20; sack_perm_pres = 1;
    ts_pres = 1; ts_snd = 32'h11223344;
    start = 1;
    @(negedge clk);
    start = 0;
    got = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (val && rdy) got++;
      @(negedge clk);
    end
    chk("abort/bytes_before", got, 2);
    chk("abort/busy_before", busy, 1);
    rst = 1;
    @(negedge clk);
    chk("abort/val", val, 0);
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    chk("abort/offset", offset, 5);
    chk("abort/opt_len", opt_len, 0);
    rst = 0;
    clear_inputs();
    mss_pres = 1; mss = 16'h1234;
    push32(32'h02041234);
    run_job("after_rst", 4, 6, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tcp_vlg_tx_opt.md
TCP_VLG_TX_OPT -- requirements
Module: tcp_vlg_tx_opt

Interface
REQ-001 The block SHALL have one parameter: MAX_OPT_BYTES, default 40, meaning the upper bound on total emitted option bytes.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset. The ports SHALL be named clk and rst.
REQ-003 The ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; latches all option inputs
- mss_pres  in  1  emit MSS
- mss  in  16  MSS value
- wnd_pres  in  1  emit window scale
- wnd  in  8  raw window scale
- sack_perm_pres  in  1  emit SACK-permitted
- ts_pres  in  1  emit timestamp
- ts_snd  in  32  TSval
- ts_rec  in  32  TSecr
- sack_pres  in  1  emit SACK
- sack_blk  in  4x64  blocks 0..3, each {left[31:0], right[31:0]}
- sack_blk_pres  in  4  per-block present flags
- rdy  in  1  downstream accepts a byte
- dat  out  8  option byte
- val  out  1  dat valid
- len_val  out  1  opt_len/offset valid, one-cycle pulse
- opt_len  out  6  total option bytes
- offset  out  4  TCP data offset in 32-bit words
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after the last byte is accepted

Function
REQ-004 start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored. On an accepted start, all inputs SHALL be registered and busy SHALL assert on the next cycle.
REQ-005 Emission order SHALL be fixed, skipping any option that is absent:
- MSS: 02 04 mss[15:8] mss[7:0]
- WND: 01 03 03 scl
- SACK_PERM: 01 01 04 02
- TS: 01 01 08 0A ts_snd (MSB first) ts_rec (MSB first)
- SACK: 01 01 05 (2+8n) then each present block: left MSB-first, then right MSB-first
REQ-006 scl SHALL be min(wnd, 14).
REQ-007 SACK blocks SHALL be emitted in ascending index order. The block count n SHALL equal popcount(sack_blk_pres), truncated to the largest n that keeps opt_len ≤ MAX_OPT_BYTES. Higher-index blocks SHALL be dropped first.
REQ-008 If n=0, the SACK option SHALL be omitted entirely, even when sack_pres=1.
REQ-009 Every option group is a multiple of 4 bytes, so no END/NOP padding SHALL be appended. opt_len SHALL equal the sum of group lengths.
REQ-010 offset SHALL equal 5 + opt_len/4.
REQ-011 len_val SHALL pulse exactly one cycle after the accepted start. opt_len and offset SHALL hold their values until the next accepted start.
REQ-012 The first byte SHALL present with val=1 no earlier than the cycle after start. A byte SHALL be transferred on a cycle where val&&rdy. dat SHALL hold stable while val=1 and rdy=0.
REQ-013 The FSM SHALL have states IDLE, CALC, MSS, WND, SPERM, TS, SACK, DONE. Within each state a byte counter SHALL run. A state is entered only if its option is present.
REQ-014 When the last byte transfers, done SHALL pulse in the next cycle, and busy SHALL deassert in that same cycle.
REQ-015 If no option is present, the block SHALL produce opt_len=0, offset=5, and no val. len_val and done SHALL both pulse in the cycle after start.
REQ-016 val SHALL never assert while busy=0.

Reset
REQ-017 rst SHALL force dat=0, val=0, len_val=0, opt_len=0, offset=5, busy=0, done=0, and FSM=IDLE on the next edge.
REQ-018 rst asserted mid-stream SHALL abort the job with no done pulse. The block SHALL accept start in the first cycle after rst deasserts.

Configuration
REQ-019 When macro TCP_VLG_SACK_EN is defined, SPERM and SACK SHALL behave per REQ-005/007/008.
REQ-020 When TCP_VLG_SACK_EN is undefined, sack_perm_pres, sack_pres, sack_blk and sack_blk_pres SHALL be ignored, the SPERM and SACK states SHALL be absent, and opt_len SHALL never include them.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- mss_pres=1, mss=16'h05B4, others 0, rdy=1 -> bytes 02 04 05 B4; opt_len=4; offset=6; done one cycle after the 4th byte.
- mss=05B4, wnd=20, sack_perm, ts_snd=11223344, ts_rec=0, rdy=1 -> 02 04 05 B4 01 03 03 0E 01 01 04 02 01 01 08 0A 11 22 33 44 00 00 00 00; opt_len=24; offset=11.
- ts_pres=1, sack_pres=1, sack_blk_pres=4'b1111 (SACK_EN) -> 3 blocks emitted; SACK len byte 0x1A; opt_len=40; offset=15.
- all pres=0 -> opt_len=0, offset=5, no val; len_val and done in the cycle after start.
- mss only, rdy toggling 1010..., second start during busy -> dat stable while rdy=0; second start ignored; exactly 4 bytes.
- rst asserted after the 2nd byte of a 24-byte job -> val=0, busy=0 next cycle; no done; a new start completes normally.
